// File: rtl/acq_pkg.sv
// Shared types and constants for the ADC acquisition sample packer.
package acq_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_IDLE      = 2'd1,
    ST_RUN       = 2'd2,
    ST_DRAIN     = 2'd3
  } acq_state_t;

  localparam int WORD_W      = 16;
  localparam int ENTRY_W     = 17;
  localparam int SYNC_STAGES = 2;

  // A FIFO entry carries the burst-last flag above the packed word.
  function automatic logic [ENTRY_W-1:0] make_entry(input logic last,
                                                    input logic [WORD_W-1:0] word);
    return {last, word};
  endfunction

endpackage

// File: rtl/acq_word_fifo.sv
// Synchronous word FIFO with flush; head entry is presented combinationally
// from storage so it stays stable until popped.
module acq_word_fifo
  import acq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  input  logic               flush,
  output logic [ENTRY_W-1:0] head,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [ENTRY_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [AW:0]        count_r;
  logic               do_push_s;
  logic               do_pop_s;

  assign empty     = (count_r == (AW+1)'(0));
  assign full      = (count_r == (AW+1)'(DEPTH));
  assign do_pop_s  = pop && !empty && !flush;
  // A full FIFO still accepts a push when the same cycle pops.
  assign do_push_s = push && !flush && (!full || do_pop_s);
  assign head      = mem_r[rd_ptr_r];

  // Storage write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/acq_sample_packer.sv
// ADC byte sampler: waits for stable PLL lock, strobes the ADC bus at a
// programmable rate, packs byte pairs into 16-bit words and streams them
// out through a small FIFO with burst framing.
module acq_sample_packer
  import acq_pkg::*;
#(
  parameter int LOCK_WAIT  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int BURST_LEN  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic              start,
  input  logic              stop,
  input  logic [7:0]        adc_data,
  input  logic [7:0]        sample_div,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              ready_lock,
  output logic              overflow,
  output logic [15:0]       sample_count
);

  localparam int BW = $clog2(BURST_LEN);
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_LEN - 1);
  localparam logic [BW-1:0] BURST_ONE  = BW'(1);
  localparam logic [7:0]    LOCK_LAST  = 8'(LOCK_WAIT - 1);

  logic [SYNC_STAGES-1:0] lock_sync_r;
  logic                   lock_s;
  acq_state_t             state_r;
  acq_state_t             state_next_s;
  logic [7:0]             lock_cnt_r;
  logic [7:0]             div_lat_r;
  logic [7:0]             div_r;
  logic                   pending_r;
  logic [7:0]             lo_r;
  logic                   push_r;
  logic [WORD_W-1:0]      word_r;
  logic [BW-1:0]          burst_cnt_r;
  logic [15:0]            sample_count_r;
  logic                   overflow_r;
  logic                   busy_r;
  logic                   ready_lock_r;

  logic                   start_run_s;
  logic                   lost_s;
  logic                   strobe_s;
  logic                   final_s;
  logic                   fifo_push_s;
  logic [WORD_W-1:0]      push_word_s;
  logic                   push_last_s;
  logic                   pop_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [ENTRY_W-1:0]     fifo_head_s;

  assign lock_s      = lock_sync_r[SYNC_STAGES-1];
  assign start_run_s = (state_r == ST_IDLE) && lock_s && start;
  assign lost_s      = !lock_s && (state_r != ST_WAIT_LOCK);
  assign strobe_s    = (state_r == ST_RUN) && lock_s && (div_r == div_lat_r);
  // The word in flight is the acquisition's last when no further byte can
  // follow it: anything pushed in DRAIN, or a word pushed in the stop cycle
  // when that cycle does not also capture a byte.
  assign final_s     = (state_r == ST_DRAIN) || ((state_r == ST_RUN) && stop && !strobe_s);
  assign fifo_push_s = !lost_s && (push_r || ((state_r == ST_DRAIN) && pending_r));
  assign push_word_s = push_r ? word_r : {8'h00, lo_r};
  assign push_last_s = (burst_cnt_r == BURST_LAST) || final_s;
  assign pop_s       = !fifo_empty_s && out_ready;

  assign out_valid    = !fifo_empty_s;
  assign out_data     = fifo_head_s[WORD_W-1:0];
  assign out_last     = fifo_head_s[ENTRY_W-1];
  assign busy         = busy_r;
  assign ready_lock   = ready_lock_r;
  assign overflow     = overflow_r;
  assign sample_count = sample_count_r;

  // Two-flop synchroniser for the asynchronous PLL lock indicator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_sync_r <= '0;
    else        lock_sync_r <= {lock_sync_r[SYNC_STAGES-2:0], pll_lock};
  end

  // Next-state logic; loss of lock overrides every other transition.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_WAIT_LOCK: begin
        if (lock_s && (lock_cnt_r == LOCK_LAST)) state_next_s = ST_IDLE;
        else                                     state_next_s = ST_WAIT_LOCK;
      end
      ST_IDLE: begin
        if (!lock_s)     state_next_s = ST_WAIT_LOCK;
        else if (start)  state_next_s = ST_RUN;
        else             state_next_s = ST_IDLE;
      end
      ST_RUN: begin
        if (!lock_s)     state_next_s = ST_WAIT_LOCK;
        else if (stop)   state_next_s = ST_DRAIN;
        else             state_next_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (!lock_s)                                   state_next_s = ST_WAIT_LOCK;
        else if (fifo_empty_s && !pending_r && !push_r) state_next_s = ST_IDLE;
        else                                           state_next_s = ST_DRAIN;
      end
      default: state_next_s = ST_WAIT_LOCK;
    endcase
  end

  // State register with status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_WAIT_LOCK;
      busy_r       <= 1'b0;
      ready_lock_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      busy_r       <= (state_next_s == ST_RUN) || (state_next_s == ST_DRAIN);
      ready_lock_r <= (state_next_s != ST_WAIT_LOCK);
    end
  end

  // Consecutive synchronised lock-high counter, only live in WAIT_LOCK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                                          lock_cnt_r <= 8'd0;
    else if ((state_r == ST_WAIT_LOCK) && lock_s && (lock_cnt_r != LOCK_LAST)) lock_cnt_r <= lock_cnt_r + 8'd1;
    else                                                                 lock_cnt_r <= 8'd0;
  end

  // Strobe divider: counts 0..div_lat_r in RUN, restarting after each strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_lat_r <= 8'd0;
      div_r     <= 8'd0;
    end else if (start_run_s) begin
      div_lat_r <= sample_div;
      div_r     <= 8'd0;
    end else if (strobe_s) begin
      div_r     <= 8'd0;
    end else if (state_r == ST_RUN) begin
      div_r     <= div_r + 8'd1;
    end else begin
      div_r     <= div_r;
    end
  end

  // Byte packer: first byte waits as the low half, second completes a word
  // that is pushed one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 1'b0;
      lo_r      <= 8'd0;
      push_r    <= 1'b0;
      word_r    <= 16'd0;
    end else if (lost_s || start_run_s) begin
      pending_r <= 1'b0;
      push_r    <= 1'b0;
    end else if (strobe_s) begin
      if (pending_r) begin
        word_r    <= {adc_data, lo_r};
        push_r    <= 1'b1;
        pending_r <= 1'b0;
      end else begin
        lo_r      <= adc_data;
        push_r    <= 1'b0;
        pending_r <= 1'b1;
      end
    end else begin
      push_r <= 1'b0;
      if ((state_r == ST_DRAIN) && pending_r) pending_r <= 1'b0;
    end
  end

  // Acquisition counters: saturating byte count, sticky overflow, burst index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_count_r <= 16'd0;
      overflow_r     <= 1'b0;
      burst_cnt_r    <= '0;
    end else if (start_run_s) begin
      sample_count_r <= 16'd0;
      overflow_r     <= 1'b0;
      burst_cnt_r    <= '0;
    end else begin
      if (strobe_s && (sample_count_r != 16'hFFFF)) sample_count_r <= sample_count_r + 16'd1;
      if (fifo_push_s && fifo_full_s && !pop_s)     overflow_r     <= 1'b1;
      if (fifo_push_s)                              burst_cnt_r    <= burst_cnt_r + BURST_ONE;
    end
  end

  acq_word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push_s),
    .push_data(make_entry(push_last_s, push_word_s)),
    .pop      (pop_s),
    .flush    (lost_s),
    .head     (fifo_head_s),
    .full     (fifo_full_s),
    .empty    (fifo_empty_s)
  );

endmodule

// File: tb/tb_acq_sample_packer.sv
// Self-checking bench for acq_sample_packer: scenario tasks compare the
// output stream against words computed from the driven bytes.
module tb_acq_sample_packer;

  localparam int LOCK_WAIT  = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int BURST_LEN  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pll_lock;
  logic        start;
  logic        stop;
  logic [7:0]  adc_data;
  logic [7:0]  sample_div;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic        ready_lock;
  logic        overflow;
  logic [15:0] sample_count;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          ready_mode = 0;
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];
  logic [7:0]  bytes_a [0:127];
  logic        valid_hist [0:255];
  logic        hold_prev = 1'b0;
  logic [16:0] prev_ent = 17'd0;

  always #5 clk = ~clk;

  acq_sample_packer #(
    .LOCK_WAIT(LOCK_WAIT), .FIFO_DEPTH(FIFO_DEPTH), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .start(start), .stop(stop),
    .adc_data(adc_data), .sample_div(sample_div), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .ready_lock(ready_lock), .overflow(overflow),
    .sample_count(sample_count)
  );

  // out_ready source: 0 = stalled, 1 = always ready, 2 = random 75% ready.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  // Collect transferred words and check stability under backpressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      if (hold_prev && out_valid) begin
        chk_cnt++;
        if ({out_last, out_data} !== prev_ent)
          $display("FAIL hold_stable: got %h want %h", {out_last, out_data}, prev_ent);
        else pass_cnt++;
      end
      hold_prev = out_valid && !out_ready;
      prev_ent  = {out_last, out_data};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) bytes_a[i] = 8'($urandom_range(0, 255));
  endtask

  // One full acquisition of n bytes at period div+1, stop on the last strobe.
  task automatic run_acq(input int div, input int n);
    int p;
    int nw;
    int guard;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       lst;
    p  = div + 1;
    nw = (n + 1) / 2;
    got_q.delete();
    exp_q.delete();
    for (int k = 0; k < nw; k++) begin
      lo  = bytes_a[2*k];
      hi  = (2*k + 1 < n) ? bytes_a[2*k+1] : 8'h00;
      lst = (((k + 1) % BURST_LEN) == 0) || (k == nw - 1);
      exp_q.push_back({lst, hi, lo});
    end
    sample_div = 8'(div);
    start = 1'b1;
    adc_data = bytes_a[0];
    step();
    start = 1'b0;
    chk_cnt++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow);
    else pass_cnt++;
    for (int c = 0; c < n * p; c++) begin
      adc_data = bytes_a[c / p];
      stop = (c == n * p - 1);
      if (c < 256) valid_hist[c] = out_valid;
      if (c == p - 1) begin
        chk_cnt++;
        if (sample_count !== 16'd0) $display("FAIL early_strobe: got %0d want 0", sample_count);
        else pass_cnt++;
      end
      step();
    end
    stop = 1'b0;
    chk_cnt++;
    if (sample_count !== 16'(n)) $display("FAIL sample_count: got %0d want %0d", sample_count, n);
    else pass_cnt++;
    guard = 0;
    while (busy && guard < 400) begin
      step();
      guard++;
    end
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL busy_fall: got %b want 0", busy);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (got_q.size() != exp_q.size())
      $display("FAIL word_count: got %0d want %0d", got_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk_cnt++;
      if (got_q[i] !== exp_q[i])
        $display("FAIL word%0d: got last=%b data=%h want last=%b data=%h",
                 i, got_q[i][16], got_q[i][15:0], exp_q[i][16], exp_q[i][15:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_lock = 1'b0; start = 1'b0; stop = 1'b0;
    adc_data = 8'h00; sample_div = 8'h00; ready_mode = 0;
    repeat (3) step();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_last !== 1'b0) $display("FAIL rst_last: got %b want 0", out_last); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (ready_lock !== 1'b0) $display("FAIL rst_ready_lock: got %b want 0", ready_lock); else pass_cnt++;
    chk_cnt++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow); else pass_cnt++;
    chk_cnt++; if (out_data !== 16'd0) $display("FAIL rst_data: got %h want 0000", out_data); else pass_cnt++;
    chk_cnt++; if (sample_count !== 16'd0) $display("FAIL rst_count: got %0d want 0", sample_count); else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  // ready_lock must rise LOCK_WAIT + 2 (synchroniser) edges after the last rise.
  task automatic test_lock_qual();
    bit early;
    early = 1'b0;
    pll_lock = 1'b1;
    repeat (10) begin step(); if (ready_lock) early = 1'b1; end
    pll_lock = 1'b0;
    step(); if (ready_lock) early = 1'b1;
    pll_lock = 1'b1;
    for (int e = 1; e < LOCK_WAIT + 2; e++) begin step(); if (ready_lock) early = 1'b1; end
    chk_cnt++; if (early) $display("FAIL lock_early: got 1 want 0 before edge %0d", LOCK_WAIT + 2); else pass_cnt++;
    step();
    chk_cnt++; if (ready_lock !== 1'b1) $display("FAIL lock_rise: got %b want 1", ready_lock); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL lock_busy: got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_basic_pack();
    ready_mode = 1; step(); step();
    bytes_a[0] = 8'h11; bytes_a[1] = 8'h22; bytes_a[2] = 8'h33; bytes_a[3] = 8'h44;
    run_acq(0, 4);
    chk_cnt++; if (valid_hist[2] !== 1'b0) $display("FAIL latency_early: got %b want 0", valid_hist[2]); else pass_cnt++;
    chk_cnt++; if (valid_hist[3] !== 1'b1) $display("FAIL latency: got %b want 1", valid_hist[3]); else pass_cnt++;
  endtask

  task automatic test_odd_drain();
    ready_mode = 1; step();
    bytes_a[0] = 8'hA1; bytes_a[1] = 8'hB2; bytes_a[2] = 8'hC3;
    run_acq(2, 3);
  endtask

  task automatic test_backpressure();
    int guard;
    ready_mode = 0; step(); step();
    fill_random(12);
    got_q.delete();
    sample_div = 8'd0; start = 1'b1; adc_data = bytes_a[0];
    step();
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      adc_data = bytes_a[c];
      stop = (c == 11);
      step();
    end
    stop = 1'b0;
    step(); step();
    chk_cnt++; if (overflow !== 1'b1) $display("FAIL bp_overflow: got %b want 1", overflow); else pass_cnt++;
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", out_valid); else pass_cnt++;
    chk_cnt++;
    if (out_data !== {bytes_a[1], bytes_a[0]}) $display("FAIL bp_head: got %h want %h", out_data, {bytes_a[1], bytes_a[0]});
    else pass_cnt++;
    chk_cnt++; if (got_q.size() != 0) $display("FAIL bp_no_xfer: got %0d want 0", got_q.size()); else pass_cnt++;
    ready_mode = 1;
    guard = 0;
    while (busy && guard < 100) begin step(); guard++; end
    step();
    chk_cnt++; if (busy !== 1'b0) $display("FAIL bp_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (sample_count !== 16'd12) $display("FAIL bp_count: got %0d want 12", sample_count); else pass_cnt++;
    chk_cnt++;
    if (got_q.size() != FIFO_DEPTH) $display("FAIL bp_words: got %0d want %0d", got_q.size(), FIFO_DEPTH);
    else pass_cnt++;
    for (int k = 0; k < FIFO_DEPTH && k < got_q.size(); k++) begin
      chk_cnt++;
      if (got_q[k] !== {1'b0, bytes_a[2*k+1], bytes_a[2*k]})
        $display("FAIL bp_word%0d: got %h want %h", k, got_q[k], {1'b0, bytes_a[2*k+1], bytes_a[2*k]});
      else pass_cnt++;
    end
  endtask

  task automatic test_burst();
    ready_mode = 1; step();
    fill_random(32);
    run_acq(0, 32);
  endtask

  task automatic test_back_to_back();
    int div;
    int n;
    for (int r = 0; r < 6; r++) begin
      div = $urandom_range(2, 5);
      n   = $urandom_range(1, 20);
      ready_mode = 2;
      fill_random(n);
      run_acq(div, n);
      chk_cnt++; if (overflow !== 1'b0) $display("FAIL b2b_overflow: got %b want 0", overflow); else pass_cnt++;
    end
  endtask

  task automatic test_lock_loss();
    int guard;
    ready_mode = 0; step(); step();
    fill_random(8);
    got_q.delete();
    sample_div = 8'd1; start = 1'b1; adc_data = bytes_a[0];
    step();
    start = 1'b0;
    for (int c = 0; c < 9; c++) begin
      adc_data = bytes_a[c / 2];
      step();
    end
    chk_cnt++; if (out_valid !== 1'b1) $display("FAIL ll_queued: got %b want 1", out_valid); else pass_cnt++;
    pll_lock = 1'b0;
    adc_data = bytes_a[4];
    step(); step(); step();
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL ll_flush: got %b want 0", out_valid); else pass_cnt++;
    chk_cnt++; if (ready_lock !== 1'b0) $display("FAIL ll_state: got %b want 0", ready_lock); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL ll_busy: got %b want 0", busy); else pass_cnt++;
    chk_cnt++; if (sample_count !== 16'd5) $display("FAIL ll_count: got %0d want 5", sample_count); else pass_cnt++;
    repeat (10) step();
    chk_cnt++; if (sample_count !== 16'd5) $display("FAIL ll_count_hold: got %0d want 5", sample_count); else pass_cnt++;
    chk_cnt++; if (got_q.size() != 0) $display("FAIL ll_no_xfer: got %0d want 0", got_q.size()); else pass_cnt++;
    pll_lock = 1'b1;
    guard = 0;
    while (!ready_lock && guard < 60) begin step(); guard++; end
    chk_cnt++; if (ready_lock !== 1'b1) $display("FAIL ll_relock: got %b want 1", ready_lock); else pass_cnt++;
    ready_mode = 1; step();
    fill_random(6);
    run_acq(1, 6);
  endtask

  initial begin
    test_reset();
    test_lock_qual();
    test_basic_pack();
    test_odd_drain();
    test_backpressure();
    test_burst();
    test_back_to_back();
    test_lock_loss();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
